// File: rtl/mdio_receptor_multi.sv
// Clause-22 MDIO management-slave receiver answering a window of PHY_CNT addresses from PHY_BASE.
// Define MDIO_PREAMBLE_CHECK_EN to require PREAMBLE_LEN sampled ones before each ST.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for first ST bit (0), preamble counted if enabled
// ST1     | expecting second ST bit (1)
// OP      | shifting 2 opcode bits
// PHYAD   | shifting 5 PHY address bits
// REGAD   | shifting 5 register address bits, decide frame at k14
// WTA     | write turnaround, must sample 1 then 0
// WDATA   | shifting 16 write data bits
// RTA     | read turnaround, drive 0 then load RD_DATA
// RDATA   | serializing read data on MDIO_IN
// SKIP    | ignoring the rest of a foreign or invalid frame
module mdio_receptor_multi #(
    parameter logic [4:0] PHY_BASE     = 5'h00,
    parameter int         PHY_CNT      = 1,
    parameter int         PREAMBLE_LEN = 32
) (
    input  logic        MDC,
    input  logic        RESET,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic        MDIO_DONE,
    output logic [2:0]  PHY_SEL,
    output logic [4:0]  ADDR,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    input  logic [15:0] RD_DATA
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ST1   = 4'd1;
    localparam logic [3:0] S_OP    = 4'd2;
    localparam logic [3:0] S_PHYAD = 4'd3;
    localparam logic [3:0] S_REGAD = 4'd4;
    localparam logic [3:0] S_WTA   = 4'd5;
    localparam logic [3:0] S_WDATA = 4'd6;
    localparam logic [3:0] S_RTA   = 4'd7;
    localparam logic [3:0] S_RDATA = 4'd8;
    localparam logic [3:0] S_SKIP  = 4'd9;

    if (PHY_CNT < 1 || PHY_CNT > 8 || PREAMBLE_LEN < 1) begin : g_bad_param
        $error("mdio_receptor_multi: PHY_CNT must be 1..8 and PREAMBLE_LEN >= 1");
    end

    logic [3:0]  state;
    logic [4:0]  bit_cnt;
    logic [1:0]  op;
    logic [4:0]  phyad;
    logic [3:0]  regad;
    logic        ta_first;
    logic [15:0] shift;

    logic [4:0]  phy_off;
    logic        phy_hit;
    logic        op_wr;
    logic        op_rd;
    logic        pre_ok;

    // Offset wraps mod 32, so a window crossing address 31 still matches.
    assign phy_off = phyad - PHY_BASE;
    assign phy_hit = (phy_off < 5'(PHY_CNT));
    assign op_wr   = (op == 2'b01);
    assign op_rd   = (op == 2'b10);

`ifdef MDIO_PREAMBLE_CHECK_EN
    localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

    logic [PRE_W-1:0] pre_left;

    assign pre_ok = (pre_left == '0);

    // Reloads outside IDLE, so every frame needs a fresh preamble.
    always_ff @(posedge MDC) begin
        if (RESET || state != S_IDLE || !MDIO_OE || !MDIO_OUT) begin
            pre_left <= PRE_W'(PREAMBLE_LEN);
        end else if (pre_left != '0) begin
            pre_left <= pre_left - PRE_W'(1);
        end
    end
`else
    assign pre_ok = 1'b1;
`endif

    always_ff @(posedge MDC) begin
        if (RESET) begin
            state      <= S_IDLE;
            bit_cnt    <= 5'd0;
            op         <= 2'b00;
            phyad      <= 5'd0;
            regad      <= 4'd0;
            ta_first   <= 1'b0;
            shift      <= 16'd0;
            MDIO_IN    <= 1'b0;
            MDIO_IN_OE <= 1'b0;
            MDIO_DONE  <= 1'b0;
            PHY_SEL    <= 3'd0;
            ADDR       <= 5'd0;
            WR_DATA    <= 16'd0;
            WR_STB     <= 1'b0;
            RD_STB     <= 1'b0;
        end else begin
            WR_STB    <= 1'b0;
            RD_STB    <= 1'b0;
            MDIO_DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (MDIO_OE && !MDIO_OUT && pre_ok) begin
                        state <= S_ST1;
                    end
                end
                S_ST1: begin
                    if (MDIO_OE && MDIO_OUT) begin
                        state   <= S_OP;
                        bit_cnt <= 5'd1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_OP: begin
                    if (!MDIO_OE) begin
                        state <= S_IDLE;
                    end else begin
                        op <= {op[0], MDIO_OUT};
                        if (bit_cnt == 5'd0) begin
                            state   <= S_PHYAD;
                            bit_cnt <= 5'd4;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                S_PHYAD: begin
                    if (!MDIO_OE) begin
                        state <= S_IDLE;
                    end else begin
                        phyad <= {phyad[3:0], MDIO_OUT};
                        if (bit_cnt == 5'd0) begin
                            state   <= S_REGAD;
                            bit_cnt <= 5'd4;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                S_REGAD: begin
                    if (!MDIO_OE) begin
                        state <= S_IDLE;
                    end else begin
                        regad <= {regad[2:0], MDIO_OUT};
                        if (bit_cnt != 5'd0) begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end else if (phy_hit && (op_wr || op_rd)) begin
                            ADDR    <= {regad, MDIO_OUT};
                            PHY_SEL <= phy_off[2:0];
                            bit_cnt <= 5'd1;
                            if (op_wr) begin
                                state <= S_WTA;
                            end else begin
                                state  <= S_RTA;
                                RD_STB <= 1'b1;
                            end
                        end else begin
                            state   <= S_SKIP;
                            bit_cnt <= 5'd17;
                        end
                    end
                end
                S_WTA: begin
                    if (!MDIO_OE) begin
                        state <= S_IDLE;
                    end else if (bit_cnt != 5'd0) begin
                        ta_first <= MDIO_OUT;
                        bit_cnt  <= 5'd0;
                    end else if (ta_first && !MDIO_OUT) begin
                        state   <= S_WDATA;
                        bit_cnt <= 5'd15;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (!MDIO_OE) begin
                        state <= S_IDLE;
                    end else begin
                        shift <= {shift[14:0], MDIO_OUT};
                        if (bit_cnt == 5'd0) begin
                            WR_DATA   <= {shift[14:0], MDIO_OUT};
                            WR_STB    <= 1'b1;
                            MDIO_DONE <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                S_RTA: begin
                    // RD_DATA is taken on the second turnaround edge, two cycles after RD_STB.
                    if (bit_cnt != 5'd0) begin
                        MDIO_IN_OE <= 1'b1;
                        MDIO_IN    <= 1'b0;
                        bit_cnt    <= 5'd0;
                    end else begin
                        shift   <= {RD_DATA[14:0], 1'b0};
                        MDIO_IN <= RD_DATA[15];
                        state   <= S_RDATA;
                        bit_cnt <= 5'd15;
                    end
                end
                S_RDATA: begin
                    if (bit_cnt != 5'd0) begin
                        MDIO_IN <= shift[15];
                        shift   <= {shift[14:0], 1'b0};
                        bit_cnt <= bit_cnt - 5'd1;
                    end else begin
                        MDIO_IN    <= 1'b0;
                        MDIO_IN_OE <= 1'b0;
                        MDIO_DONE  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt == 5'd0) begin
                        state <= S_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_receptor_multi.sv
// Bench for mdio_receptor_multi: two instances (single PHY at 0, window 4..7) share one MDIO bus.
// Build with MDIO_PREAMBLE_CHECK_EN defined to exercise the preamble gate.
module tb_mdio_receptor_multi;

    logic        MDC = 1'b0;
    logic        RESET;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;

    logic        mdio_in_a, in_oe_a, done_a, wr_stb_a, rd_stb_a;
    logic [2:0]  sel_a;
    logic [4:0]  addr_a;
    logic [15:0] wrd_a;
    logic        mdio_in_b, in_oe_b, done_b, wr_stb_b, rd_stb_b;
    logic [2:0]  sel_b;
    logic [4:0]  addr_b;
    logic [15:0] wrd_b;

`ifdef MDIO_PREAMBLE_CHECK_EN
    localparam int B2B_PRE = 32;
`else
    localparam int B2B_PRE = 0;
`endif

    mdio_receptor_multi #(.PHY_BASE(5'h00), .PHY_CNT(1), .PREAMBLE_LEN(32)) u_a (
        .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(mdio_in_a), .MDIO_IN_OE(in_oe_a), .MDIO_DONE(done_a),
        .PHY_SEL(sel_a), .ADDR(addr_a), .WR_DATA(wrd_a),
        .WR_STB(wr_stb_a), .RD_STB(rd_stb_a), .RD_DATA(RD_DATA)
    );

    mdio_receptor_multi #(.PHY_BASE(5'h04), .PHY_CNT(4), .PREAMBLE_LEN(32)) u_b (
        .MDC(MDC), .RESET(RESET), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(mdio_in_b), .MDIO_IN_OE(in_oe_b), .MDIO_DONE(done_b),
        .PHY_SEL(sel_b), .ADDR(addr_b), .WR_DATA(wrd_b),
        .WR_STB(wr_stb_b), .RD_STB(rd_stb_b), .RD_DATA(RD_DATA)
    );

    always #5 MDC = ~MDC;

    typedef struct {
        int          wr;
        int          done;
        int          rd;
        int          oe;
        logic [16:0] rdw;
        logic [15:0] wrd;
        logic [4:0]  addr;
        logic [2:0]  sel;
    } exp_t;

    typedef struct {
        int          pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [15:0] data;
        int          abort_k;
        int          tail;
        exp_t        a;
        exp_t        b;
    } vec_t;

    int          n_chk = 0;
    int          n_err = 0;
    int          cur_k;
    int          s_wr[2], s_done[2], s_rd[2], s_oe[2];
    int          k_wr[2], k_done[2], k_rd[2];
    logic [16:0] s_rdw[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            s_wr[i] = 0; s_done[i] = 0; s_rd[i] = 0; s_oe[i] = 0;
            k_wr[i] = 0; k_done[i] = 0; k_rd[i] = 0; s_rdw[i] = '0;
        end
    endtask

    // One MDC cycle: drive, wait for the edge, then observe 1 ns later.
    task automatic tick(input logic oe, input logic b);
        MDIO_OE  = oe;
        MDIO_OUT = b;
        @(posedge MDC);
        #1;
        if (wr_stb_a) begin s_wr[0]++; k_wr[0] = cur_k; end
        if (wr_stb_b) begin s_wr[1]++; k_wr[1] = cur_k; end
        if (done_a) begin s_done[0]++; k_done[0] = cur_k; end
        if (done_b) begin s_done[1]++; k_done[1] = cur_k; end
        if (rd_stb_a) begin s_rd[0]++; k_rd[0] = cur_k; end
        if (rd_stb_b) begin s_rd[1]++; k_rd[1] = cur_k; end
        if (in_oe_a) s_oe[0]++;
        if (in_oe_b) s_oe[1]++;
        if (cur_k >= 15 && cur_k <= 31) begin
            s_rdw[0] = {s_rdw[0][15:0], mdio_in_a};
            s_rdw[1] = {s_rdw[1][15:0], mdio_in_b};
        end
    endtask

    // RD_DATA is only meaningful across the k16 edge; noise elsewhere.
    task automatic send(input vec_t v, input int stop_k);
        logic [31:0] w;
        logic        oe;
        logic        b;
        w = {2'b01, v.op, v.phy, v.rg, v.ta, v.data};
        cur_k = 0;
        for (int p = 0; p < v.pre; p++) tick(1'b1, 1'b1);
        for (int k = 1; k <= stop_k; k++) begin
            RD_DATA = (k == 16) ? v.data : (16'hDEAD ^ 16'(k));
            if (v.op == 2'b10 && k >= 15) begin
                oe = 1'b0; b = 1'b1;
            end else begin
                oe = 1'b1; b = w[32-k];
            end
            if (v.abort_k != 0 && k >= v.abort_k) oe = 1'b0;
            cur_k = k;
            tick(oe, b);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t        e;
        string       tag;
        logic [15:0] wrd;
        logic [4:0]  addr;
        logic [2:0]  sel;
        clear_stats();
        send(v, 32);
        for (int t = 0; t < v.tail; t++) begin
            cur_k = 33 + t;
            tick(1'b0, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                e = v.a; tag = $sformatf("v%0d.a", idx); wrd = wrd_a; addr = addr_a; sel = sel_a;
            end else begin
                e = v.b; tag = $sformatf("v%0d.b", idx); wrd = wrd_b; addr = addr_b; sel = sel_b;
            end
            chk({tag, ".wr_stb_cycles"}, s_wr[i], e.wr);
            chk({tag, ".done_cycles"}, s_done[i], e.done);
            chk({tag, ".rd_stb_cycles"}, s_rd[i], e.rd);
            chk({tag, ".in_oe_cycles"}, s_oe[i], e.oe);
            chk({tag, ".read_bits"}, 32'(s_rdw[i]), 32'(e.rdw));
            chk({tag, ".wr_data"}, 32'(wrd), 32'(e.wrd));
            chk({tag, ".addr"}, 32'(addr), 32'(e.addr));
            chk({tag, ".phy_sel"}, 32'(sel), 32'(e.sel));
            if (e.wr != 0) chk({tag, ".wr_stb_k"}, k_wr[i], 32);
            if (e.done != 0) chk({tag, ".done_k"}, k_done[i], 32);
            if (e.rd != 0) chk({tag, ".rd_stb_k"}, k_rd[i], 14);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[11];
        vec_t r;
        vec_t p;

        //           pre  op     phy    reg    ta     data      abk tail
        //           a: wr done rd oe rdw wrd addr sel        b: same
        vecs[0]  = '{32, 2'b01, 5'h00, 5'h05, 2'b10, 16'h5A5A, 0, 2,
                     '{1,1,0,0, 17'h0, 16'h5A5A, 5'h05, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h00, 3'd0}};
        vecs[1]  = '{32, 2'b10, 5'h06, 5'h03, 2'b00, 16'hABCD, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h05, 3'd0}, '{0,1,1,17, 17'h0ABCD, 16'h0000, 5'h03, 3'd2}};
        vecs[2]  = '{32, 2'b10, 5'h01, 5'h07, 2'b00, 16'h1111, 0, 0,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h05, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h03, 3'd2}};
        vecs[3]  = '{B2B_PRE, 2'b01, 5'h07, 5'h1F, 2'b10, 16'h1234, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h05, 3'd0}, '{1,1,0,0, 17'h0, 16'h1234, 5'h1F, 3'd3}};
        vecs[4]  = '{32, 2'b01, 5'h00, 5'h0A, 2'b11, 16'h0000, 17, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h0A, 3'd0}, '{0,0,0,0, 17'h0, 16'h1234, 5'h1F, 3'd3}};
        vecs[5]  = '{32, 2'b01, 5'h00, 5'h11, 2'b10, 16'hFFFF, 20, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h11, 3'd0}, '{0,0,0,0, 17'h0, 16'h1234, 5'h1F, 3'd3}};
        vecs[6]  = '{32, 2'b10, 5'h00, 5'h02, 2'b00, 16'h8001, 0, 2,
                     '{0,1,1,17, 17'h08001, 16'h5A5A, 5'h02, 3'd0}, '{0,0,0,0, 17'h0, 16'h1234, 5'h1F, 3'd3}};
        vecs[7]  = '{32, 2'b01, 5'h04, 5'h00, 2'b10, 16'h0000, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h02, 3'd0}, '{1,1,0,0, 17'h0, 16'h0000, 5'h00, 3'd0}};
        vecs[8]  = '{32, 2'b10, 5'h03, 5'h01, 2'b00, 16'h7777, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h02, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h00, 3'd0}};
        vecs[9]  = '{32, 2'b10, 5'h07, 5'h10, 2'b00, 16'h0F0F, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h02, 3'd0}, '{0,1,1,17, 17'h00F0F, 16'h0000, 5'h10, 3'd3}};
        vecs[10] = '{32, 2'b01, 5'h08, 5'h04, 2'b10, 16'h9999, 0, 2,
                     '{0,0,0,0, 17'h0, 16'h5A5A, 5'h02, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h10, 3'd3}};

        RESET    = 1'b1;
        MDIO_OE  = 1'b0;
        MDIO_OUT = 1'b1;
        RD_DATA  = 16'h0000;
        cur_k    = 0;
        repeat (2) @(posedge MDC);
        #1;
        chk("reset.a.in", 32'(mdio_in_a), 0);
        chk("reset.a.in_oe", 32'(in_oe_a), 0);
        chk("reset.a.done", 32'(done_a), 0);
        chk("reset.a.wr_stb", 32'(wr_stb_a), 0);
        chk("reset.a.rd_stb", 32'(rd_stb_a), 0);
        chk("reset.a.addr", 32'(addr_a), 0);
        chk("reset.a.wr_data", 32'(wrd_a), 0);
        chk("reset.b.in_oe", 32'(in_oe_b), 0);
        chk("reset.b.phy_sel", 32'(sel_b), 0);
        chk("reset.b.addr", 32'(addr_b), 0);
        RESET = 1'b0;

        for (int v = 0; v < 11; v++) run_vec(vecs[v], v);

        // Reset in the middle of a read, after k23 with MDIO_IN_OE driven.
        r = '{32, 2'b10, 5'h05, 5'h09, 2'b00, 16'hC3A5, 0, 2,
              '{0,0,0,0, 17'h0, 16'h0000, 5'h00, 3'd0}, '{0,1,1,17, 17'h0C3A5, 16'h0000, 5'h09, 3'd1}};
        clear_stats();
        send(r, 23);
        chk("midread.b.in_oe", 32'(in_oe_b), 1);
        chk("midread.b.addr", 32'(addr_b), 32'h09);
        chk("midread.b.phy_sel", 32'(sel_b), 1);
        chk("midread.b.rd_stb_cycles", s_rd[1], 1);
        RESET = 1'b1;
        cur_k = 24;
        tick(1'b0, 1'b1);
        chk("rst.b.in", 32'(mdio_in_b), 0);
        chk("rst.b.in_oe", 32'(in_oe_b), 0);
        chk("rst.b.done", 32'(done_b), 0);
        chk("rst.b.wr_stb", 32'(wr_stb_b), 0);
        chk("rst.b.rd_stb", 32'(rd_stb_b), 0);
        chk("rst.b.phy_sel", 32'(sel_b), 0);
        chk("rst.b.addr", 32'(addr_b), 0);
        chk("rst.b.wr_data", 32'(wrd_b), 0);
        chk("rst.a.addr", 32'(addr_a), 0);
        chk("rst.a.wr_data", 32'(wrd_a), 0);
        RESET = 1'b0;
        run_vec(r, 11);

        // Preamble gate: 31 ones then 32 ones before the same write to PHY 0.
`ifdef MDIO_PREAMBLE_CHECK_EN
        p = '{31, 2'b01, 5'h00, 5'h06, 2'b10, 16'h4321, 0, 2,
              '{0,0,0,0, 17'h0, 16'h0000, 5'h00, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h09, 3'd1}};
`else
        p = '{31, 2'b01, 5'h00, 5'h06, 2'b10, 16'h4321, 0, 2,
              '{1,1,0,0, 17'h0, 16'h4321, 5'h06, 3'd0}, '{0,0,0,0, 17'h0, 16'h0000, 5'h09, 3'd1}};
`endif
        run_vec(p, 12);
        p.pre = 32;
        p.a   = '{1,1,0,0, 17'h0, 16'h4321, 5'h06, 3'd0};
        run_vec(p, 13);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mdio_receptor_multi.md
# mdio_receptor_multi

Multi-PHY, Clause-22 MDIO management-slave receiver: samples controller frames on `MDIO_OUT` and decodes ST/OP/PHYAD/REGAD/TA/DATA. It responds to a contiguous window of PHY addresses, issues register-file write strobes, and requests and serializes read data back on `MDIO_IN` with its own output enable. It is the parametrised successor of `mdio_receptor`, sitting between the MDIO pad logic and the per-PHY register banks.

## Interface
Parameters:
- `PHY_BASE`, 5'h00, first PHY address answered.
- `PHY_CNT`, 1, number of consecutive PHY addresses answered (1..8); `PHYAD` in [PHY_BASE, PHY_BASE+PHY_CNT-1] mod 32 matches.
- `PREAMBLE_LEN`, 32, minimum consecutive sampled ones before ST (used only with `MDIO_PREAMBLE_CHECK_EN`).

Ports:
- `MDC` input 1: MDIO clock; all logic on its rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `MDIO_OUT` input 1: controller-driven serial bit.
- `MDIO_OE` input 1: controller drive enable; a bit is valid only when 1.
- `MDIO_IN` output 1: serial bit driven back to controller.
- `MDIO_IN_OE` output 1: receptor drive enable for `MDIO_IN`.
- `MDIO_DONE` output 1: one-cycle pulse at completed write or read frame.
- `PHY_SEL` output 3: `PHYAD - PHY_BASE` of the current frame.
- `ADDR` output 5: REGAD of the current frame.
- `WR_DATA` output 16: write payload.
- `WR_STB` output 1: one-cycle write strobe.
- `RD_STB` output 1: one-cycle read request.
- `RD_DATA` input 16: register read data, sampled 2 cycles after `RD_STB`.

## Operation
- Bit index k counts qualifying rising edges: k=1 is the first ST bit. Fields are ST k1-2, OP k3-4, PHYAD k5-9, REGAD k10-14, TA k15-16 and DATA k17-32. All fields are MSB first.
- States: IDLE, ST1, OP, PHYAD, REGAD, WTA, WDATA, RTA, RDATA, SKIP.
- IDLE: sampled 0 with `MDIO_OE`=1 goes to ST1.
- ST1: sampled 1 goes to OP; sampled 0 returns to IDLE.
- OP: 01 selects write, 10 selects read; 00 and 11 are invalid.
- After k14, the frame goes to SKIP if the PHY does not match or the OP is invalid. Otherwise it goes to WTA for a write or RTA for a read.
- SKIP: counts 18 edges regardless of `MDIO_OE`, then returns to IDLE. No strobes, no drive.
- Write frame: TA must sample 1,0. Any other TA pattern goes to IDLE with no strobe. WDATA then shifts 16 bits.
- Controller-driven phases are ST through REGAD, plus WTA and WDATA. In these phases `MDIO_OE`=0 aborts to IDLE with no strobe and no `MDIO_DONE`.
- Read frame: `MDIO_OE` and `MDIO_OUT` are ignored from k15 to k32.
- Reset values: state IDLE; `MDIO_IN`=0, `MDIO_IN_OE`=0, `MDIO_DONE`=0, `WR_STB`=0, `RD_STB`=0, `PHY_SEL`=0, `ADDR`=0, `WR_DATA`=0.
- `RESET` mid-frame: reset values take effect at the next edge, and `MDIO_IN_OE` drops at that edge.
- `ADDR` and `PHY_SEL` update after k14 and hold until the next matching frame's k14.
- `WR_DATA` holds until the next write strobe.

## Timing
- Write: after k32 the block drives `WR_STB`=1, `MDIO_DONE`=1 and `WR_DATA` valid, all high for exactly one cycle. Latency from the last data bit to the strobe is 1 edge.
- Read:
  - After k14: `RD_STB`=1 for one cycle.
  - After k15: `MDIO_IN_OE`=1, `MDIO_IN`=0 (second TA bit).
  - At k16: `RD_DATA` is latched into the shift register and `MDIO_IN` becomes D15.
  - After k17..k31: `MDIO_IN` carries D14..D0.
  - After k32: `MDIO_IN_OE`=0 and `MDIO_DONE`=1 for one cycle.
- Back-to-back: the next ST may begin on the edge immediately after k32, or after the SKIP end.
- Without the preamble macro, no idle cycles are needed between frames.

## Configuration
- `MDIO_PREAMBLE_CHECK_EN` defined:
  - IDLE counts consecutive sampled ones with `MDIO_OE`=1, saturating at `PREAMBLE_LEN`.
  - A 0 or `MDIO_OE`=0 clears the count.
  - ST is accepted only when count ≥ `PREAMBLE_LEN`; a 0 sampled earlier clears the count and stays in IDLE.
  - The count clears on every frame end or abort, so each frame requires a fresh preamble.
- Not defined: no preamble counter; IDLE goes to ST1 on any sampled 0.

## Test plan
- Write, PHY_BASE=0, PHY_CNT=1: 32 ones, 01 01 00000 00101 10 16'h5A5A. Expect one-cycle `WR_STB`, `ADDR`=5'h05, `WR_DATA`=16'h5A5A and `MDIO_DONE`; `MDIO_IN_OE` stays 0.
- Read, PHY_BASE=4, PHY_CNT=4, PHYAD=6, REGAD=3, `RD_DATA`=16'hABCD. Expect `PHY_SEL`=2, `ADDR`=3 and `RD_STB` after k14. `MDIO_IN` after k15..k31 is 0 then 1010101111001101; `MDIO_IN_OE` high for 17 cycles, then `MDIO_DONE`.
- Non-matching PHYAD=1 with PHY_BASE=4: no strobes, no `MDIO_IN_OE`. An immediately following matching write completes normally.
- Write with TA=11, and a write with `MDIO_OE` dropped at k20: both return to IDLE with no `WR_STB` and no `MDIO_DONE`; `WR_DATA` keeps its old value.
- `RESET` asserted at k24 of a read: `MDIO_IN_OE`=0 and all outputs at reset values on the next edge. A subsequent read returns correct data.
- With `MDIO_PREAMBLE_CHECK_EN`: a frame preceded by 31 ones is ignored; the same frame with 32 ones produces `WR_STB`.
